// File: rtl/fp_accum_seq.sv
// fp_accum_seq: streaming FP accumulator controller that feeds an external adder
// with (running sum, next operand) pairs and returns the final sum, count and overflow.
module fp_accum_seq #(
   parameter int LAT   = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   output logic             add_en,
   input  logic [31:0]      add_sum,
   input  logic             add_of,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_sum,
   output logic             out_of,
   output logic [CNT_W-1:0] out_count
);
   localparam int WW = (LAT > 0) ? $clog2(LAT + 1) : 1;
   typedef enum logic [1:0] {EMPTY, ACC, WAIT, DONE} state_t;
   state_t           state_q, state_d;
   logic [31:0]      acc_q, acc_d, hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             of_q, of_d, last_q, last_d;
   logic [WW-1:0]    wcnt_q, wcnt_d;
   logic             cap;
   assign in_ready  = (state_q == EMPTY) || (state_q == ACC);
   assign add_en    = state_q == WAIT;
   assign out_valid = state_q == DONE;
   assign add_a     = acc_q;
   assign add_b     = hold_q;
   assign out_sum   = acc_q;
   assign out_of    = of_q;
   assign out_count = cnt_q;
   // the adder result is only trusted once its pipeline has drained
   assign cap = (state_q == WAIT) && (wcnt_q == WW'(LAT));
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      of_d    = of_q;
      last_d  = last_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         EMPTY: if (in_valid) begin
            acc_d   = in_data;
            cnt_d   = CNT_W'(1);
            of_d    = 1'b0;
            state_d = in_last ? DONE : ACC;
         end
         ACC: if (in_valid) begin
            hold_d  = in_data;
            last_d  = in_last;
            cnt_d   = cnt_q + CNT_W'(~&cnt_q);
            wcnt_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wcnt_d = wcnt_q + WW'(1);
            if (cap) begin
               acc_d   = add_sum;
               of_d    = of_q | add_of;
               state_d = last_q ? DONE : ACC;
            end
         end
         DONE: if (out_ready) begin
            state_d = EMPTY;
            cnt_d   = '0;
            of_d    = 1'b0;
            acc_d   = '0;
            hold_d  = '0;
         end
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= EMPTY;
         acc_q   <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
         of_q    <= 1'b0;
         last_q  <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         of_q    <= of_d;
         last_q  <= last_d;
         wcnt_q  <= wcnt_d;
      end
   end
endmodule

// File: tb/tb_fp_accum_seq.sv
// tb_fp_accum_seq: drives a combinational-adder instance (LAT=0, 3-bit counter) and a
// registered-adder instance (LAT=2) against a stream-level reference model.
module tb_fp_accum_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid [2], in_ready [2], in_last [2];
   logic        add_en [2], add_of [2], out_valid [2], out_ready [2], out_of [2];
   logic [31:0] in_data [2], add_a [2], add_b [2], add_sum [2], out_sum [2];
   logic [15:0] out_count [2];
   logic [2:0]  oc0;
   logic [32:0] p1 = '0, p2 = '0;
   int          checks = 0, errors = 0, cyc = 0;
   int          m_n [2] = '{0, 0};
   int          en_n [2] = '{0, 0};
   int          acc_cyc [2] = '{0, 0};
   logic [31:0] m_sum [2];
   logic        m_of [2];
   logic        ov_prev [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_accum_seq #(.LAT(0), .CNT_W(3)) u0 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_last(in_last[0]), .add_a(add_a[0]), .add_b(add_b[0]),
      .add_en(add_en[0]), .add_sum(add_sum[0]), .add_of(add_of[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_sum(out_sum[0]), .out_of(out_of[0]), .out_count(oc0));
   assign out_count[0] = {13'b0, oc0};

   fp_accum_seq #(.LAT(2), .CNT_W(16)) u1 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_last(in_last[1]), .add_a(add_a[1]), .add_b(add_b[1]),
      .add_en(add_en[1]), .add_sum(add_sum[1]), .add_of(add_of[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_sum(out_sum[1]), .out_of(out_of[1]), .out_count(out_count[1]));

   // stand-in adder: exact results for the known FP pairs, integer add with carry as overflow otherwise
   function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
      if (a == 32'h40400000 && b == 32'h40400000) return {1'b0, 32'h40C00000};
      if (a == 32'h3F000000 && b == 32'h3F800000) return {1'b0, 32'h3FC00000};
      if (a == 32'h3F800000 && b == 32'h3F800000) return {1'b0, 32'h40000000};
      if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {1'b1, 32'h7F800000};
      return {1'b0, a} + {1'b0, b};
   endfunction

   assign {add_of[0], add_sum[0]} = fadd(add_a[0], add_b[0]);
   always @(posedge clk) if (add_en[1]) begin
      p1 <= fadd(add_a[1], add_b[1]);
      p2 <= p1;
   end
   assign {add_of[1], add_sum[1]} = p2;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // stream-level reference: fold the adder over accepted operands, check on consumption
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_n[d] = 0;
            en_n[d] = 0;
            ov_prev[d] = 1'b0;
         end else begin
            if (add_en[d]) begin
               en_n[d]++;
               chk("wait_in_ready", 128'(in_ready[d]), 128'(0));
            end
            if (out_valid[d] && !ov_prev[d])
               chk("valid_latency", 128'(cyc - acc_cyc[d]), 128'(m_n[d] == 1 ? 1 : (d == 0 ? 2 : 4)));
            if (out_valid[d] && out_ready[d]) begin
               chk("mdl_sum", 128'(out_sum[d]), 128'(m_sum[d]));
               chk("mdl_of", 128'(out_of[d]), 128'(m_of[d]));
               chk("mdl_count", 128'(out_count[d]),
                   128'(m_n[d] > (d == 0 ? 7 : 65535) ? (d == 0 ? 7 : 65535) : m_n[d]));
               chk("mdl_add_en_cycles", 128'(en_n[d]), 128'((m_n[d] - 1) * (d == 0 ? 1 : 3)));
               m_n[d] = 0;
               en_n[d] = 0;
            end
            if (in_valid[d] && in_ready[d]) begin
               if (m_n[d] == 0) begin
                  m_sum[d] = in_data[d];
                  m_of[d] = 1'b0;
               end else begin
                  m_of[d] = m_of[d] | fadd(m_sum[d], in_data[d])[32];
                  m_sum[d] = fadd(m_sum[d], in_data[d])[31:0];
               end
               m_n[d]++;
               acc_cyc[d] = cyc;
            end
            ov_prev[d] = out_valid[d];
         end
      end
   end

   task automatic push(input int d, input logic [31:0] data, input logic last);
      int t = 0;
      while (!in_ready[d] && t < 100) begin
         in_valid[d] = 1'($urandom_range(0, 1));
         in_data[d] = in_valid[d] ? data : $urandom;
         in_last[d] = in_valid[d] ? last : 1'($urandom);
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready[d]) chk("push_ready_timeout", 128'(in_ready[d]), 128'(1));
      repeat ($urandom_range(0, 2)) begin
         in_valid[d] = 1'b0;
         in_data[d] = $urandom;
         in_last[d] = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid[d] = 1'b1;
      in_data[d] = data;
      in_last[d] = last;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic get_result(input int d, input string name, input bit ce, input logic [31:0] es,
                             input logic eo, input int ec, input int hold);
      int t = 0;
      logic [48:0] snap;
      bit ok = 1;
      while (!out_valid[d] && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk({name, "_valid"}, 128'(out_valid[d]), 128'(1));
      snap = {out_sum[d], out_of[d], out_count[d]};
      repeat (hold) begin
         @(posedge clk); #1;
         if ({out_sum[d], out_of[d], out_count[d]} !== snap || !out_valid[d] || in_ready[d]) ok = 0;
      end
      chk({name, "_hold_stable"}, 128'(ok), 128'(1));
      if (ce) begin
         chk({name, "_sum"}, 128'(out_sum[d]), 128'(es));
         chk({name, "_of"}, 128'(out_of[d]), 128'(eo));
         chk({name, "_count"}, 128'(out_count[d]), 128'(ec));
      end
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
      chk({name, "_consumed"}, 128'({out_valid[d], in_ready[d], out_sum[d], out_count[d]}),
          128'({1'b0, 1'b1, 32'h0, 16'h0}));
   endtask

   task automatic chk_reset(input int d, input string name);
      chk(name, 128'({in_ready[d], add_en[d], out_valid[d], out_of[d], out_count[d],
                      add_a[d], add_b[d], out_sum[d]}), 128'({1'b1, 3'b0, 16'h0, 96'h0}));
   endtask

   typedef struct {
      int              d;
      int              n;
      logic [3:0][31:0] ops;
      int              hold;
      logic [31:0]     es;
      logic            eo;
      int              ec;
   } vec_t;
   vec_t tv [7];

   initial begin
      tv[0] = '{0, 3, {32'h0, 32'h40400000, 32'h40000000, 32'h3F800000}, 5, 32'h40C00000, 1'b0, 3};
      tv[1] = '{1, 2, {32'h0, 32'h0, 32'h3F800000, 32'h3F000000}, 0, 32'h3FC00000, 1'b0, 2};
      tv[2] = '{0, 1, {32'h0, 32'h0, 32'h0, 32'h40400000}, 1, 32'h40400000, 1'b0, 1};
      tv[3] = '{0, 2, {32'h0, 32'h0, 32'h7F7FFFFF, 32'h7F7FFFFF}, 0, 32'h7F800000, 1'b1, 2};
      tv[4] = '{0, 2, {32'h0, 32'h0, 32'h3F800000, 32'h3F800000}, 2, 32'h40000000, 1'b0, 2};
      tv[5] = '{1, 2, {32'h0, 32'h0, 32'h7F7FFFFF, 32'h7F7FFFFF}, 0, 32'h7F800000, 1'b1, 2};
      tv[6] = '{1, 2, {32'h0, 32'h0, 32'h3F800000, 32'h3F800000}, 5, 32'h40000000, 1'b0, 2};
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0;
         in_data[d] = '0;
         in_last[d] = 1'b0;
         out_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk_reset(0, "reset_lat0");
      chk_reset(1, "reset_lat2");
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < tv[i].n; j++) push(tv[i].d, tv[i].ops[j], j == tv[i].n - 1);
         get_result(tv[i].d, $sformatf("vec%0d", i), 1'b1, tv[i].es, tv[i].eo, tv[i].ec, tv[i].hold);
      end
      for (int j = 0; j < 9; j++) push(0, 32'h0, j == 8);
      get_result(0, "count_sat", 1'b1, 32'h0, 1'b0, 7, 0);
      push(0, 32'h3F800000, 1'b0);
      push(0, 32'h40000000, 1'b0);
      chk("mid_wait_add_en", 128'(add_en[0]), 128'(1));
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset(0, "reset_mid_wait");
      rst_n = 1'b1;
      push(0, 32'h40000000, 1'b1);
      get_result(0, "after_reset", 1'b1, 32'h40000000, 1'b0, 1, 0);
      for (int s = 0; s < 24; s++) begin
         int d = $urandom_range(0, 1);
         int n = $urandom_range(1, 10);
         for (int j = 0; j < n; j++) push(d, $urandom, j == n - 1);
         get_result(d, "rand", 1'b0, 32'h0, 1'b0, 0, $urandom_range(0, 3));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Streaming single-precision accumulator controller that sits directly upstream of the FP adder (`fpa` or `fpa_with_regisers`).
- Accepts a stream of IEEE 754 operands over valid/ready and feeds the adder the pairs (running sum, next operand).
- Captures the adder result back into the running sum.
- At the end of the stream, presents the final sum, an element count and a sticky overflow flag on a valid/ready output.

Parameters:
- LAT, 0, adder latency in cycles: 0 for combinational `fpa`, 2 for `fpa_with_regisers`.
- CNT_W, 16, width of the element counter.

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand this cycle
- in_data  input  32  IEEE 754 operand
- in_last  input  1  operand is last of stream; qualified by in_valid
- add_a  output  32  adder operand A (registered running sum)
- add_b  output  32  adder operand B (registered held operand)
- add_en  output  1  enable to the registered adder wrapper
- add_sum  input  32  adder result
- add_of  input  1  adder overflow flag
- out_valid  output  1  final result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  32  final accumulated sum
- out_of  output  1  sticky OR of add_of over all additions of the stream
- out_count  output  CNT_W  number of operands accepted in the stream

Behaviour:
- Registers: acc[31:0], hold[31:0], cnt[CNT_W-1:0], of_st, last_st, wcnt (counts 0..LAT), state.
- add_a = acc; add_b = hold; out_sum = acc; out_of = of_st; out_count = cnt.
- Reset (reset==0 at a clock edge): state=EMPTY; acc, hold, cnt, of_st, last_st, wcnt all 0.
  - Every output at reset: in_ready=1, add_en=0, out_valid=0, add_a=add_b=out_sum=0, out_of=0, out_count=0.
  - Reset mid-stream or mid-wait discards all progress; no output is produced for that stream.
- EMPTY: in_ready=1, add_en=0.
  - On in_valid: acc<=in_data, cnt<=1, of_st<=0.
  - If in_last, go to DONE; otherwise go to ACC. No addition is issued for the first operand.
- ACC: in_ready=1, add_en=0.
  - On in_valid: hold<=in_data, last_st<=in_last, cnt<=cnt+1 (saturating at all-ones), wcnt<=0, go to WAIT.
- WAIT: in_ready=0, add_en=1.
  - Each cycle, wcnt increments.
  - In the cycle where wcnt==LAT: acc<=add_sum, of_st<=of_st|add_of, then go to DONE if last_st, otherwise to ACC.
  - add_sum and add_of are sampled only in that cycle.
- DONE: in_ready=0, add_en=0, out_valid=1.
  - out_sum, out_of and out_count are held stable while out_valid && !out_ready.
  - On out_ready: go to EMPTY with cnt<=0, of_st<=0, acc<=0, hold<=0.
- Timing and throughput:
  - For an operand accepted at cycle T, the sum is captured at the end of cycle T+1+LAT.
  - in_ready reasserts at T+2+LAT.
  - Throughput is 1 operand per LAT+2 cycles.
  - out_valid first asserts the cycle after the last capture, or the cycle after acceptance for a 1-element stream.
- Handshake rules:
  - in_data and in_last are ignored when in_valid=0.
  - in_valid is ignored while in_ready=0 and never causes loss or duplication.
  - The upstream source must hold its data until accepted.
- Arithmetic: all FP semantics (NaN, zero, inf, denormal, normalisation) belong to the adder. This block never inspects operand fields.
- Counter: saturates at 2^CNT_W-1 and does not wrap; accumulation continues past saturation.

Test Plan:
- LAT=0; stream 1.0 (3F800000), 2.0 (40000000), 3.0 (40400000, last), out_ready=1 → out_sum=40C00000, out_count=3, out_of=0. out_valid rises 2 cycles after the accept of 3.0, and in_ready=0 during each WAIT cycle.
- LAT=2 with the registered wrapper; stream 0.5 (3F000000), 1.0 (3F800000, last) → add_en high for exactly 3 cycles, out_sum=3FC00000, out_count=2.
- Single operand 40400000 with in_last=1 → add_en never asserts, out_sum=40400000, out_count=1, DONE state reached the next cycle.
- Stream 7F7FFFFF, 7F7FFFFF (last) with the adder reporting add_of=1 → out_of=1. A following stream 3F800000, 3F800000 (last) → out_of=0, out_sum=40000000 (sticky flag cleared per stream).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0 throughout; result consumed on the first out_ready=1 cycle. Toggling in_valid during WAIT → no extra operands counted.
- Drive reset=0 during WAIT of a 3-element stream → next cycle all outputs are 0 and in_ready=1. A new stream 40000000 (last) → out_sum=40000000, out_count=1.
